// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that issues counting bursts to a shared
// dual-channel counter. A granted requester receives Len enables (0 means 16)
// on its own channel. Hold pauses a burst, and each burst is closed by a
// one-cycle DONE state.
module counter_arbiter (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req0,
    input  logic [3:0] Len0,
    input  logic       Req1,
    input  logic [3:0] Len1,
    input  logic       Hold,
    output logic       En,
    output logic       Slt,
    output logic       Ack0,
    output logic       Ack1,
    output logic       Done0,
    output logic       Done1,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    logic [4:0] rem_q,   rem_d;
    logic       ack0_q,  ack0_d;
    logic       ack1_q,  ack1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;

    logic       grant_valid;
    logic       grant_idx;
    logic [4:0] grant_len;

    // Arbitration: a lone requester wins; a tie goes to the one that was not served last.
    always_comb begin
        grant_valid = Req0 | Req1;
        if (Req0 && Req1) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = Req1;
        end
        // The MSB is set only for a zero length, so 4'd0 loads as 5'd16.
        if (grant_idx) begin
            grant_len = {(Len1 == 4'd0), Len1};
        end else begin
            grant_len = {(Len0 == 4'd0), Len0};
        end
    end

    // State, ownership, burst counter and pulse outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rem_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    // Next-state logic; Ack and Done pulses are computed one cycle ahead so they leave a register.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rem_d   = rem_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    rem_d   = grant_len;
                    state_d = RUN;
                    ack0_d  = ~grant_idx;
                    ack1_d  = grant_idx;
                end
            end
            RUN: begin
                if (!Hold) begin
                    rem_d = rem_q - 5'd1;
                    if (rem_q == 5'd1) begin
                        state_d = DONE;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enable is gated combinationally by Hold, so a pause takes effect in the same cycle.
    always_comb begin
        En    = (state_q == RUN) && !Hold;
        Slt   = owner_q;
        Busy  = (state_q != IDLE);
        Ack0  = ack0_q;
        Ack1  = ack1_q;
        Done0 = done0_q;
        Done1 = done1_q;
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed bursts followed by random traffic,
// checked cycle by cycle against a behavioural burst model.
module tb_counter_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req0, Req1, Hold;
    logic [3:0] Len0, Len1;
    logic       En, Slt, Ack0, Ack1, Done0, Done1, Busy;

    counter_arbiter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Req0  (Req0),
        .Len0  (Len0),
        .Req1  (Req1),
        .Len1  (Len1),
        .Hold  (Hold),
        .En    (En),
        .Slt   (Slt),
        .Ack0  (Ack0),
        .Ack1  (Ack1),
        .Done0 (Done0),
        .Done1 (Done1),
        .Busy  (Busy)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 = waiting, 1 = bursting, 2 = closing cycle.
    int m_mode, m_owner, m_last, m_left, m_ack;

    // Requester-side stimulus state.
    bit       r[2];
    bit       drop[2];
    bit [3:0] ln[2];
    bit       hold_v;

    // Observations of the DUT, used only for scenario-level checks.
    int obs_en[2];
    int obs_done;
    int obs_run;
    int obs_grants[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_owner = 0;
        m_last  = 1;
        m_left  = 0;
        m_ack   = -1;
    endtask

    task automatic clear_obs();
        obs_en[0] = 0;
        obs_en[1] = 0;
        obs_done  = 0;
        obs_run   = 0;
        obs_grants.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_En"}, En, 1'b0);
        chk({tag, "_Slt"}, Slt, 1'b0);
        chk({tag, "_Ack0"}, Ack0, 1'b0);
        chk({tag, "_Ack1"}, Ack1, 1'b0);
        chk({tag, "_Done0"}, Done0, 1'b0);
        chk({tag, "_Done1"}, Done1, 1'b0);
        chk({tag, "_Busy"}, Busy, 1'b0);
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model.
    task automatic cycle();
        bit       q0, q1, h;
        bit [3:0] l0, l1;
        int       g, n;
        q0 = r[0]; q1 = r[1]; l0 = ln[0]; l1 = ln[1]; h = hold_v;
        Req0 = q0; Req1 = q1; Len0 = l0; Len1 = l1; Hold = h;
        @(negedge Clk);
        chk("En",    En,    (m_mode == 1) && !h);
        chk("Slt",   Slt,   m_owner == 1);
        chk("Ack0",  Ack0,  m_ack == 0);
        chk("Ack1",  Ack1,  m_ack == 1);
        chk("Done0", Done0, (m_mode == 2) && (m_owner == 0));
        chk("Done1", Done1, (m_mode == 2) && (m_owner == 1));
        chk("Busy",  Busy,  m_mode != 0);
        if (En === 1'b1) obs_en[Slt === 1'b1 ? 1 : 0]++;
        if (Ack0 === 1'b1) obs_grants.push_back(0);
        if (Ack1 === 1'b1) obs_grants.push_back(1);
        if (Done0 === 1'b1 || Done1 === 1'b1) obs_done++;
        if (Busy === 1'b1 && Done0 !== 1'b1 && Done1 !== 1'b1) obs_run++;
        // A requester that sees its acknowledge may withdraw next cycle.
        if (m_ack >= 0 && drop[m_ack]) r[m_ack] = 1'b0;
        case (m_mode)
            0: begin
                m_ack = -1;
                if (q0 || q1) begin
                    if (q0 && q1) g = 1 - m_last;
                    else          g = q0 ? 0 : 1;
                    n = (g == 0) ? int'(l0) : int'(l1);
                    m_owner = g;
                    m_last  = g;
                    m_left  = (n == 0) ? 16 : n;
                    m_mode  = 1;
                    m_ack   = g;
                end
            end
            1: begin
                m_ack = -1;
                if (!h) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
            end
            default: begin
                m_ack  = -1;
                m_mode = 0;
            end
        endcase
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #2;
        check_all_zero(tag);
        r[0] = 1'b0; r[1] = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0; Hold = 1'b0; Len0 = '0; Len1 = '0;
        r[0] = 1'b0; r[1] = 1'b0; drop[0] = 1'b1; drop[1] = 1'b1;
        ln[0] = '0; ln[1] = '0; hold_v = 1'b0;
        model_reset();
        #12;
        check_all_zero("rst");
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Single burst on channel 0, length 3.
        clear_obs();
        r[0] = 1'b1; ln[0] = 4'd3;
        repeat (8) cycle();
        chk_int("b3_en_ch0", obs_en[0], 3);
        chk_int("b3_en_ch1", obs_en[1], 0);
        chk_int("b3_done", obs_done, 1);

        // Channel 1, length 8; downstream channel 1 counts every 4th enable.
        clear_obs();
        r[1] = 1'b1; ln[1] = 4'd8;
        repeat (13) cycle();
        chk_int("b8_en_ch1", obs_en[1], 8);
        chk_int("b8_out1", obs_en[1] / 4, 2);

        // Simultaneous requests from reset: order 0, 1, then 0 again.
        do_reset("rst2");
        clear_obs();
        r[0] = 1'b1; r[1] = 1'b1; ln[0] = 4'd2; ln[1] = 4'd5;
        repeat (12) cycle();
        chk_int("rr_en_ch0", obs_en[0], 2);
        chk_int("rr_en_ch1", obs_en[1], 5);
        r[0] = 1'b1; r[1] = 1'b1; ln[0] = 4'd1; ln[1] = 4'd1;
        repeat (10) cycle();
        chk_int("rr_grants", obs_grants.size(), 4);
        if (obs_grants.size() >= 3) begin
            chk_int("rr_g0", obs_grants[0], 0);
            chk_int("rr_g1", obs_grants[1], 1);
            chk_int("rr_g2", obs_grants[2], 0);
        end

        // Length 0 means 16 enables; four held cycles stretch the burst to 20.
        clear_obs();
        r[0] = 1'b1; ln[0] = 4'd0;
        repeat (6) cycle();
        hold_v = 1'b1;
        repeat (4) cycle();
        hold_v = 1'b0;
        repeat (16) cycle();
        chk_int("l16_en", obs_en[0], 16);
        chk_int("l16_run", obs_run, 20);

        // Reset on the third enable of a length-10 burst.
        clear_obs();
        r[1] = 1'b1; ln[1] = 4'd10;
        for (int k = 0; k < 12 && obs_en[1] < 2; k++) cycle();
        chk_int("rst_mid_pre", obs_en[1], 2);
        Req1 = r[1]; Hold = 1'b0;
        #2;
        chk("rst_mid_en3", En, 1'b1);
        Reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        r[0] = 1'b0; r[1] = 1'b0;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk_int("rst_mid_nodone", obs_done, 0);
        clear_obs();
        r[1] = 1'b1; ln[1] = 4'd2;
        repeat (6) cycle();
        chk_int("post_rst_grants", obs_grants.size(), 1);
        chk_int("post_rst_en", obs_en[1], 2);
        chk_int("post_rst_done", obs_done, 1);

        // Random traffic with Len churn, Hold pauses and re-requests after Ack.
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!r[j] && $urandom_range(0, 2) == 0) r[j] = 1'b1;
                ln[j]   = 4'($urandom_range(0, 15));
                drop[j] = ($urandom_range(0, 3) != 0);
            end
            hold_v = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
